// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, imem request FSM (FETCH/WAIT/DRAIN) and IF/ID pipeline register.
// One-cycle fetch-to-IF/ID latency when imem_ready is high; memory waits and redirect drains insert bubbles.
module if_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        PC_write,
  input  logic        IFID_write,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  input  logic        Jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic        fetch_stall,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        redirect;
  logic [31:0] target;
  logic        capture;
  logic        stall;
  logic [31:0] fetch_addr;
  logic [31:0] next_seq;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_cnt_d  = stall_cnt_q;
    capture      = 1'b0;
    stall        = 1'b0;

    // Redirects are only honoured once the load-use stall has cleared.
    redirect   = PC_write & (PCSrc | Jump);
    target     = Jump ? {ifid_pc_q[31:28], jump_index, 2'b00} : branch_target;
    fetch_addr = (state_q == S_FETCH) ? pc_q : req_addr_q;
    next_seq   = fetch_addr + 32'd4;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          capture = 1'b1;
        end else begin
          stall      = 1'b1;
          req_addr_d = pc_q;
          state_d    = redirect ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ready) begin
          capture = 1'b1;
          state_d = S_FETCH;
        end else begin
          stall = 1'b1;
          if (redirect) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The response in flight belongs to the abandoned path.
        stall = 1'b1;
        if (imem_ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (redirect) begin
      pc_d         = target;
      ifid_instr_d = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (capture) begin
      if (PC_write) begin
        pc_d = next_seq;
        if (IFID_write) begin
          ifid_pc_d    = next_seq;
          ifid_instr_d = imem_data;
          ifid_valid_d = 1'b1;
        end
      end
    end else if (stall && IFID_write) begin
      ifid_instr_d = 32'h0;
      ifid_valid_d = 1'b0;
    end

    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= 32'h0;
      req_addr_q   <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= 16'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign imem_addr    = fetch_addr;
  assign imem_req     = ~reset;
  assign fetch_stall  = reset ? 1'b0 : stall;
  assign IFID_PC      = ifid_pc_q;
  assign IFID_instr   = ifid_instr_q;
  assign IFID_valid   = ifid_valid_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: stimulus pushes expected per-cycle outputs from a transaction-level fetch model; a monitor pops and compares.
module tb_if_fetch_unit;

  localparam logic [31:0] DATA_KEY = 32'h5A3C_0001;

  logic        clock = 1'b0;
  logic        reset;
  logic        PC_write, IFID_write, PCSrc, Jump, imem_ready;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_data, IFID_PC, IFID_instr;
  logic        imem_req, IFID_valid, fetch_stall;
  logic [15:0] stall_cycles;

  if_fetch_unit dut (
    .clock(clock), .reset(reset), .PC_write(PC_write), .IFID_write(IFID_write),
    .PCSrc(PCSrc), .branch_target(branch_target), .Jump(Jump), .jump_index(jump_index),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready), .imem_data(imem_data),
    .IFID_PC(IFID_PC), .IFID_instr(IFID_instr), .IFID_valid(IFID_valid),
    .fetch_stall(fetch_stall), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Memory contents: every word differs from its address and is never zero.
  assign imem_data = imem_addr ^ DATA_KEY;

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic        stall;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        ifvalid;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   running = 1'b0;

  // Reference model: program counter, one outstanding memory request, and whether its reply is stale.
  logic [31:0] m_pc, m_req_addr, m_ifpc, m_ifinstr;
  logic        m_inflight, m_discard, m_ifvalid;
  int          m_cnt;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_pc = 0; m_req_addr = 0; m_ifpc = 0; m_ifinstr = 0;
    m_inflight = 0; m_discard = 0; m_ifvalid = 0; m_cnt = 0;
  endtask

  task automatic cyc(input logic rst, input logic pw, input logic iw, input logic src, input logic jmp,
                     input logic [31:0] bt, input logic [25:0] ji, input logic rdy);
    exp_t        e;
    logic [31:0] addr, tgt;
    logic        redir, got;
    @(posedge clock);
    #2;
    reset = rst; PC_write = pw; IFID_write = iw; PCSrc = src; Jump = jmp;
    branch_target = bt; jump_index = ji; imem_ready = rdy;
    if (rst) begin
      model_reset();
      e.addr = 0; e.req = 0; e.stall = 0; e.ifpc = 0; e.ifinstr = 0; e.ifvalid = 0; e.cnt = 0;
      sb.push_back(e);
    end else begin
      addr = m_inflight ? m_req_addr : m_pc;
      got  = rdy && !m_discard;
      e.addr = addr; e.req = 1; e.stall = !got;
      e.ifpc = m_ifpc; e.ifinstr = m_ifinstr; e.ifvalid = m_ifvalid; e.cnt = 16'(m_cnt);
      sb.push_back(e);

      redir = pw && (src || jmp);
      tgt   = jmp ? {m_ifpc[31:28], ji, 2'b00} : bt;
      if (!got && m_cnt < 65535) m_cnt++;
      if (redir) begin
        m_ifinstr = 0; m_ifvalid = 0;
      end else if (got && pw && iw) begin
        m_ifpc = addr + 32'd4; m_ifinstr = addr ^ DATA_KEY; m_ifvalid = 1;
      end else if (!got && iw) begin
        m_ifinstr = 0; m_ifvalid = 0;
      end
      if (redir) m_pc = tgt;
      else if (got && pw) m_pc = addr + 32'd4;
      if (rdy) begin
        m_inflight = 0; m_discard = 0;
      end else begin
        if (!m_inflight) begin
          m_inflight = 1; m_req_addr = addr;
        end
        if (redir) m_discard = 1;
      end
    end
  endtask

  task automatic go(input logic rdy);
    cyc(0, 1, 1, 0, 0, 32'h0, 26'h0, rdy);
  endtask

  task automatic branch(input logic [31:0] bt, input logic rdy);
    cyc(0, 1, 1, 1, 0, bt, 26'h0, rdy);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("imem_req", 32'(imem_req), 32'(e.req));
        chk("fetch_stall", 32'(fetch_stall), 32'(e.stall));
        chk("IFID_PC", IFID_PC, e.ifpc);
        chk("IFID_instr", IFID_instr, e.ifinstr);
        chk("IFID_valid", 32'(IFID_valid), 32'(e.ifvalid));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
      end else if (running) begin
        chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    fails++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : stimulus
    logic [31:0] r;
    reset = 1; PC_write = 0; IFID_write = 0; PCSrc = 0; Jump = 0;
    branch_target = 0; jump_index = 0; imem_ready = 0;
    model_reset();
    running = 1'b1;

    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    // Sequential fetch 0,4,8 then a one-cycle hazard hold at PC=8.
    go(1); go(1);
    cyc(0, 0, 0, 0, 0, 32'h0, 26'h0, 1);
    go(1); go(1);
    // Branch at PC=0x10 to 0x40.
    branch(32'h40, 1);
    go(1);
    // Three-cycle memory wait at 0x20, then capture.
    branch(32'h20, 1);
    go(0); go(0); go(0); go(1);
    // Jump while waiting: IFID_PC=0x1000_0004, wait at 0x20, drain, resume at 0x1000_0040.
    branch(32'h1000_0000, 1);
    go(1);
    branch(32'h20, 1);
    go(0);
    cyc(0, 1, 1, 0, 1, 32'h0, 26'h10, 0);
    go(1); go(1); go(1);
    // PC wrap at the top of the address space.
    branch(32'hFFFF_FFFC, 1);
    go(1); go(1);
    // Reset mid-wait abandons the request; first capture afterwards is address 0.
    go(0); go(0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    go(1); go(1);

    for (int i = 0; i < 600; i++) begin
      logic pw;
      r  = $urandom;
      pw = ($urandom_range(0, 7) != 0);
      cyc(0, pw, pw, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
          r & 32'hFFFF_FFFC, 26'($urandom), ($urandom_range(0, 2) != 0));
    end

    // Long wait drives the stall counter into saturation.
    for (int i = 0; i < 65540; i++) go(0);
    go(1); go(1); go(0); go(1);

    @(negedge clock);
    #1;
    running = 1'b0;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces reset state immediately, independent of clock.
REQ-003 SHALL have port: PC_write  input  1  from hazard unit; 0 = hold PC (load-use stall).
REQ-004 SHALL have port: IFID_write  input  1  from hazard unit; 0 = hold IF/ID register.
REQ-005 SHALL have port: PCSrc  input  1  taken branch (BEQ/BNE) resolved in ID.
REQ-006 SHALL have port: branch_target  input  32  branch destination byte address.
REQ-007 SHALL have port: Jump  input  1  J decoded in ID.
REQ-008 SHALL have port: jump_index  input  26  instr_index field of the J in IF/ID.
REQ-009 SHALL have port: imem_addr  output  32  instruction memory byte address.
REQ-010 SHALL have port: imem_req  output  1  fetch request.
REQ-011 SHALL have port: imem_ready  input  1  imem_data valid for imem_addr this cycle.
REQ-012 SHALL have port: imem_data  input  32  fetched instruction word.
REQ-013 SHALL have port: IFID_PC  output  32  PC+4 of the instruction held in IF/ID.
REQ-014 SHALL have port: IFID_instr  output  32  instruction held in IF/ID.
REQ-015 SHALL have port: IFID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-016 SHALL have port: fetch_stall  output  1  1 = no instruction captured this cycle due to memory wait/drain.
REQ-017 SHALL have port: stall_cycles  output  16  count of cycles with fetch_stall=1.

Function
REQ-018 SHALL hold a 32-bit PC register and a 3-state FSM: FETCH, WAIT, DRAIN.
REQ-019 SHALL drive imem_addr = PC in FETCH; in WAIT/DRAIN imem_addr = req_addr, the PC latched on leaving FETCH, held stable.
REQ-020 SHALL drive imem_req = 1 in every non-reset cycle.
REQ-021 SHALL compute redirect = PC_write & (PCSrc | Jump); Jump wins if both set; jump target = {IFID_PC[31:28], jump_index, 2'b00}.
REQ-022 SHALL ignore PCSrc/Jump while PC_write=0; ID holds them asserted until the stall clears.
REQ-023 FETCH & imem_ready=1: if redirect, PC <= target and IF/ID <= bubble; else if PC_write, PC <= PC+4 and, if IFID_write, IF/ID <= {PC+4, imem_data, valid=1}.
REQ-024 FETCH & imem_ready=0: req_addr <= PC, state -> WAIT, fetch_stall=1, PC held unless redirect, in which case PC <= target and state -> DRAIN.
REQ-025 WAIT: fetch_stall=1; on imem_ready=1 behave as FETCH-capture per REQ-023 (using req_addr data), state -> FETCH; on redirect without ready, PC <= target, state -> DRAIN.
REQ-026 DRAIN: fetch_stall=1; imem_ready=1 response discarded, state -> FETCH; further redirects update PC only.
REQ-027 SHALL load IF/ID with bubble (IFID_instr=32'h0, IFID_valid=0, IFID_PC unchanged) whenever fetch_stall=1 and IFID_write=1, or on any redirect regardless of IFID_write.
REQ-028 SHALL hold IF/ID unchanged when IFID_write=0 and no redirect.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 stall_cycles SHALL increment each cycle fetch_stall=1 and saturate at 16'hFFFF.
REQ-031 Latency: instruction at PC with imem_ready=1 appears on IFID_instr one cycle later.

Reset
REQ-032 On reset: PC=0, state=FETCH, req_addr=0, IFID_PC=0, IFID_instr=0, IFID_valid=0, stall_cycles=0; fetch_stall=0, imem_addr=0.
REQ-033 Reset asserted mid-WAIT/DRAIN SHALL abandon the outstanding fetch; first post-reset capture is address 0.

Verification
REQ-034 reset, imem_ready=1 always, 3 cycles -> imem_addr 0,4,8; IFID_PC 4,8,12 with valid=1, one-cycle lag.
REQ-035 PC_write=0, IFID_write=0 one cycle at PC=8 -> PC stays 8, IF/ID unchanged, stall_cycles unchanged.
REQ-036 PCSrc=1, branch_target=0x40 at PC=0x10 -> next imem_addr 0x40, IF/ID bubble (instr 0, valid 0).
REQ-037 imem_ready=0 for 3 cycles at PC=0x20 -> addr held 0x20, 3 bubbles, stall_cycles=3, then capture with IFID_PC=0x24.
REQ-038 Jump (jump_index=0x10, IFID_PC=0x1000_0004) during WAIT at 0x20 -> DRAIN; first ready discarded; next fetch addr 0x1000_0040.
REQ-039 PC=0xFFFF_FFFC fetch -> next PC 0; stall_cycles preloaded by 65536 stall cycles -> remains 0xFFFF.
